// File: rtl/acm_loop_engine.sv
// Stream engine between the muacm OUT and IN pipes: FWFT FIFO carrying {last, data}
// with echo / case-swap / generator / sink modes. Optional counters: ACM_LOOP_CNT_EN.
module acm_loop_engine #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned GEN_LEN = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [7:0]              out_data,
    input  logic                    out_last,
    input  logic                    out_valid,
    output logic                    out_ready,
    output logic [7:0]              in_data,
    output logic                    in_last,
    output logic                    in_valid,
    input  logic                    in_ready,
    output logic                    in_flush_now,
    output logic                    in_flush_time,
    output logic [$clog2(DEPTH):0]  level,
    output logic [1:0]              active_mode,
    output logic [15:0]             rx_cnt,
    output logic [15:0]             tx_cnt
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned LW       = AW + 1;
    localparam logic [7:0]  GEN_LAST = 8'(GEN_LEN - 1);
    localparam logic [1:0]  M_ECHO   = 2'd0;
    localparam logic [1:0]  M_SWAP   = 2'd1;
    localparam logic [1:0]  M_GEN    = 2'd2;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t          state;
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [7:0]      gen_byte;
    logic [7:0]      gen_idx;
    logic            full;
    logic            empty;
    logic            wr_en;
    logic            rd_en;
    logic [8:0]      wr_word;
    logic            mode_chg;
    logic            gen_last;
    logic            gen_hold;

    function automatic logic [7:0] swap_case(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b ^ 8'h20;
        return b;
    endfunction

    assign full          = (count == LW'(DEPTH));
    assign empty         = (count == '0);
    assign mode_chg      = (mode != active_mode);
    assign gen_last      = (gen_idx == GEN_LAST);
    // At a packet boundary a pending mode change must not start a new packet
    assign gen_hold      = mode_chg && (gen_idx == '0);
    assign in_valid      = ~empty & ~rst;
    assign rd_en         = in_valid & in_ready;
    assign {in_last, in_data} = mem[rd_ptr];
    assign level         = count;
    assign in_flush_time = 1'b1;

    // Write source and OUT-pipe backpressure per active mode
    always_comb begin
        out_ready = 1'b0;
        wr_en     = 1'b0;
        wr_word   = '0;
        if (state == ST_RUN) begin
            case (active_mode)
                M_ECHO: begin
                    out_ready = ~full;
                    wr_en     = out_valid & ~full;
                    wr_word   = {out_last, out_data};
                end
                M_SWAP: begin
                    out_ready = ~full;
                    wr_en     = out_valid & ~full;
                    wr_word   = {out_last, swap_case(out_data)};
                end
                M_GEN: begin
                    wr_en   = ~full & ~gen_hold;
                    wr_word = {gen_last, gen_byte};
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(wr_en) - LW'(rd_en);
        end
    end

    // Mode FSM, generator state and flush pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            active_mode  <= M_ECHO;
            gen_byte     <= '0;
            gen_idx      <= '0;
            in_flush_now <= 1'b0;
        end else begin
            in_flush_now <= rd_en & in_last;
            case (state)
                ST_RUN: begin
                    if (active_mode == M_GEN && wr_en) begin
                        gen_byte <= gen_byte + 8'd1;
                        gen_idx  <= gen_last ? 8'd0 : gen_idx + 8'd1;
                    end
                    if (mode_chg && (active_mode != M_GEN || gen_hold || (wr_en && gen_last)))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (empty) begin
                        active_mode <= mode;
                        gen_byte    <= '0;
                        gen_idx     <= '0;
                        state       <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef ACM_LOOP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt <= '0;
            tx_cnt <= '0;
        end else begin
            if (out_valid && out_ready)
                rx_cnt <= rx_cnt + 16'd1;
            if (rd_en)
                tx_cnt <= tx_cnt + 16'd1;
        end
    end
`else
    assign rx_cnt = '0;
    assign tx_cnt = '0;
`endif

endmodule

// File: tb/tb_acm_loop_engine.sv
// Directed bench for acm_loop_engine (DEPTH=16, GEN_LEN=4) with hand-computed expectations.
module tb_acm_loop_engine;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned GEN_LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic        in_flush_now;
    logic        in_flush_time;
    logic [4:0]  level;
    logic [1:0]  active_mode;
    logic [15:0] rx_cnt;
    logic [15:0] tx_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    acm_loop_engine #(.DEPTH(DEPTH), .GEN_LEN(GEN_LEN)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .in_flush_now(in_flush_now), .in_flush_time(in_flush_time),
        .level(level), .active_mode(active_mode), .rx_cnt(rx_cnt), .tx_cnt(tx_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        out_data  = d;
        out_last  = l;
        out_valid = 1'b1;
        #1;
        chk("out_ready", 32'(out_ready), 32'd1);
        tick();
        out_valid = 1'b0;
    endtask

    task automatic wait_mode(input logic [1:0] m);
        int n = 0;
        while (active_mode !== m && n < 8) begin
            tick();
            n++;
        end
        chk("mode_switch", 32'(active_mode), 32'(m));
    endtask

    logic [7:0] t1_in  [4] = '{8'h10, 8'h11, 8'h12, 8'h00};
    logic [7:0] t2_in  [4] = '{8'h61, 8'h5A, 8'h35, 8'h7B};
    logic [7:0] t2_exp [4] = '{8'h41, 8'h7A, 8'h35, 8'h7B};

    initial begin
        logic seen;
        int   n;
        rst = 1'b1; mode = 2'd0; out_data = '0; out_last = 1'b0; out_valid = 1'b0; in_ready = 1'b0;
        tick(); tick();
        chk("rst_in_valid", 32'(in_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_valid2", 32'(in_valid), 32'd0);
        chk("rst_flush_now", 32'(in_flush_now), 32'd0);
        chk("rst_active_mode", 32'(active_mode), 32'd0);
        chk("flush_time", 32'(in_flush_time), 32'd1);
        chk("rst_out_ready", 32'(out_ready), 32'd1);

        // echo, one-cycle latency, flush after last
        in_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(t1_in[i], i == 2);
            chk("echo_valid", 32'(in_valid), 32'd1);
            chk("echo_data", 32'(in_data), 32'(t1_in[i]));
            chk("echo_last", 32'(in_last), 32'(i == 2));
            chk("echo_noflush", 32'(in_flush_now), 32'd0);
        end
        tick();
        chk("echo_flush", 32'(in_flush_now), 32'd1);
        chk("echo_empty", 32'(in_valid), 32'd0);
        chk("echo_level0", 32'(level), 32'd0);
        tick();
        chk("echo_flush_end", 32'(in_flush_now), 32'd0);

        // case-swap
        mode = 2'd1;
        wait_mode(2'd1);
        for (int i = 0; i < 4; i++) begin
            send(t2_in[i], i == 3);
            chk("swap_data", 32'(in_data), 32'(t2_exp[i]));
            chk("swap_last", 32'(in_last), 32'(i == 3));
        end
        tick();

        // full FIFO with in_ready low, then drain and resume
        mode = 2'd0;
        wait_mode(2'd0);
        in_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            send(8'(32'h20 + i), 1'b0);
        chk("full_level", 32'(level), 32'd16);
        out_data = 8'h30; out_last = 1'b0; out_valid = 1'b1;
        #1;
        chk("full_out_ready", 32'(out_ready), 32'd0);
        tick();
        chk("full_no_write", 32'(level), 32'd16);
        out_valid = 1'b0;
        in_ready  = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("drain_valid", 32'(in_valid), 32'd1);
            chk("drain_data", 32'(in_data), 32'h20 + j);
            tick();
        end
        chk("drain_level0", 32'(level), 32'd0);
        chk("drain_empty", 32'(in_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(8'(32'h30 + i), i == 3);
            chk("rest_data", 32'(in_data), 32'h30 + i);
        end
        tick();
        chk("rest_flush", 32'(in_flush_now), 32'd1);

        // generator: 4-byte packets, byte wraps 0xFF -> 0x00
        mode = 2'd2;
        wait_mode(2'd2);
        n = 0;
        while (in_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("gen_start", 32'(in_valid), 32'd1);
        for (int i = 0; i < 262; i++) begin
            chk("gen_valid", 32'(in_valid), 32'd1);
            chk("gen_data", 32'(in_data), 32'(i % 256));
            chk("gen_last", 32'(in_last), 32'(i % 4 == 3));
            chk("gen_flush", 32'(in_flush_now), 32'(i > 0 && (i - 1) % 4 == 3));
            chk("gen_out_ready", 32'(out_ready), 32'd0);
            if (i < 261)
                tick();
        end

        // gen -> echo mid-packet: packet completes, then drain
        in_ready = 1'b0;
        mode     = 2'd0;
        repeat (4) tick();
        chk("chg_level", 32'(level), 32'd3);
        chk("chg_out_ready", 32'(out_ready), 32'd0);
        chk("chg_mode_held", 32'(active_mode), 32'd2);
        chk("chg_head", 32'(in_data), 32'h05);
        in_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("chg_valid", 32'(in_valid), 32'd1);
            chk("chg_data", 32'(in_data), 32'h05 + k);
            chk("chg_last", 32'(in_last), 32'(k == 2));
            chk("chg_out_ready2", 32'(out_ready), 32'd0);
            tick();
        end
        wait_mode(2'd0);
        chk("chg_out_ready_on", 32'(out_ready), 32'd1);
        chk("chg_level0", 32'(level), 32'd0);
        chk("chg_empty", 32'(in_valid), 32'd0);

        // reset mid-operation discards FIFO contents
        in_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(8'(32'hA0 + i), 1'b0);
        chk("mid_level", 32'(level), 32'd3);
        chk("mid_valid", 32'(in_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(in_valid), 32'd0);
        tick();
        chk("mid_rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_post_valid", 32'(in_valid), 32'd0);

        // sink
        mode = 2'd3;
        wait_mode(2'd3);
        chk("sink_out_ready", 32'(out_ready), 32'd1);
        seen = 1'b0;
        out_data = 8'h55; out_last = 1'b0; out_valid = 1'b1;
`ifdef ACM_LOOP_CNT_EN
        repeat (65539) begin
            tick();
            seen = seen | in_valid;
        end
        out_valid = 1'b0;
        chk("sink_rx_cnt", 32'(rx_cnt), 32'd3);
        chk("sink_tx_cnt", 32'(tx_cnt), 32'd0);
`else
        repeat (5) begin
            tick();
            seen = seen | in_valid;
        end
        out_valid = 1'b0;
        chk("sink_rx_tied", 32'(rx_cnt), 32'd0);
        chk("sink_tx_tied", 32'(tx_cnt), 32'd0);
`endif
        chk("sink_no_in_valid", 32'(seen), 32'd0);
        chk("sink_level", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
